// File: rtl/controller_responder_if.sv
// Pad-side signal bundle for the Genesis-style gamepad emulator.
// The master is the host/harness side. The slave is the emulated pad.
interface controller_responder_if;
  logic        controller_select;
  logic [11:0] buttons;
  logic [5:0]  controller_pins;
  logic        frame_start;
  logic [2:0]  pulse_count;

  modport master (
    output controller_select,
    output buttons,
    input  controller_pins,
    input  frame_start,
    input  pulse_count
  );

  modport slave (
    input  controller_select,
    input  buttons,
    output controller_pins,
    output frame_start,
    output pulse_count
  );
endinterface

// File: rtl/controller_responder.sv
// Emulated 6-button Genesis pad: counts host select falls per frame and drives
// the multiplexed, active-low button group for the current phase.
module controller_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 4000,
  parameter bit          SIX_BUTTON     = 1'b1,
  parameter int unsigned TIMER_WIDTH    = 16
) (
  input logic             clock,
  input logic             reset,
  controller_responder_if.slave pad
);

  typedef enum logic [2:0] {
    CNT_IDLE = 3'd0,
    CNT_1    = 3'd1,
    CNT_2    = 3'd2,
    CNT_3    = 3'd3,
    CNT_4    = 3'd4
  } cnt_e;

  typedef struct packed {
    logic up, down, left, right, a, b, c, x, y, z, start, mode;
  } btn_t;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]             sync_q, sync_d;
  logic                   prev_q, prev_d;
  cnt_e                   cnt_q, cnt_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  btn_t                   snap_q, snap_d;
  logic [5:0]             pins_q, pins_d;
  logic                   fs_q, fs_d;

  logic sel_s, fall, rise;
  btn_t btn;
  logic six_id, six_ext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= CNT_IDLE;
      timer_q <= '0;
      snap_q  <= '0;
      pins_q  <= '1;
      fs_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      snap_q  <= snap_d;
      pins_q  <= pins_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[0], pad.controller_select};
    sel_s   = sync_q[1];
    prev_d  = sel_s;
    fall    = prev_q & ~sel_s;
    rise    = ~prev_q & sel_s;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    snap_d  = snap_q;
    fs_d    = 1'b0;

    // An edge clears the timer and takes priority over a same-cycle timeout.
    if (fall || rise) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      cnt_d = CNT_IDLE;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (fall) begin
      case (cnt_q)
        CNT_1:   cnt_d = CNT_2;
        CNT_2:   cnt_d = CNT_3;
        CNT_3:   cnt_d = CNT_4;
        default: begin
          cnt_d  = CNT_1;
          snap_d = btn_t'(pad.buttons);
          fs_d   = 1'b1;
        end
      endcase
    end
  end

  // Pins are registered from next-state count so the phase change and the data land together.
  always_comb begin
    btn     = (cnt_d == CNT_IDLE) ? btn_t'(pad.buttons) : snap_d;
    six_id  = SIX_BUTTON && (cnt_d == CNT_3);
    six_ext = SIX_BUTTON && (cnt_d == CNT_4);
    pins_d  = '1;
    if (sel_s) begin
      if (six_id) begin
        pins_d = ~{btn.z, btn.b, btn.y, btn.x, btn.mode, btn.c};
      end else begin
        pins_d = ~{btn.up, btn.b, btn.down, btn.left, btn.right, btn.c};
      end
    end else begin
      if (six_id) begin
        pins_d = {1'b0, ~btn.a, 3'b000, ~btn.start};
      end else if (six_ext) begin
        pins_d = {1'b1, ~btn.a, 3'b111, ~btn.start};
      end else begin
        pins_d = {~btn.up, ~btn.a, ~btn.down, 2'b00, ~btn.start};
      end
    end
  end

  assign pad.controller_pins = pins_q;
  assign pad.frame_start     = fs_q;
  assign pad.pulse_count     = cnt_q;

endmodule

// File: tb/tb_controller_responder.sv
// Bench for controller_responder: directed phase table on a 6- and a 3-button
// instance, reset corner case, then random select/button traffic against a model.
module tb_controller_responder;

  localparam int unsigned TO = 50;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic [11:0] btns;

  int tests  = 0;
  int failed = 0;
  int fr6    = 0;
  int fr3    = 0;

  always #5 clock = ~clock;

  controller_responder_if if6();
  controller_responder_if if3();

  assign if6.controller_select = sel;
  assign if6.buttons           = btns;
  assign if3.controller_select = sel;
  assign if3.buttons           = btns;

  controller_responder #(.TIMEOUT_CYCLES(TO), .SIX_BUTTON(1'b1), .TIMER_WIDTH(16)) dut6 (
    .clock (clock),
    .reset (reset),
    .pad   (if6.slave)
  );

  controller_responder #(.TIMEOUT_CYCLES(TO), .SIX_BUTTON(1'b0), .TIMER_WIDTH(16)) dut3 (
    .clock (clock),
    .reset (reset),
    .pad   (if3.slave)
  );

  always @(posedge clock) begin
    if (if6.frame_start === 1'b1) fr6++;
    if (if3.frame_start === 1'b1) fr3++;
  end

  typedef struct {
    logic        s;
    int          wait_n;
    logic [11:0] b;
    int          cnt;
    logic [5:0]  p6;
    logic [5:0]  p3;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Pin values straight from the phase table: bits are p5..p0, active low.
  function automatic logic [5:0] model_pins(input bit six, input int cnt, input logic s,
                                            input logic [11:0] b);
    logic u, d, l, r, a, bb, c, x, y, z, st, m;
    int ph;
    u = b[11]; d = b[10]; l = b[9]; r = b[8]; a = b[7]; bb = b[6];
    c = b[5];  x = b[4];  y = b[3]; z = b[2]; st = b[1]; m = b[0];
    ph = cnt;
    if (!six && ph >= 3) ph = ph - 2;
    if (s) begin
      if (ph == 3) return ~{z, bb, y, x, m, c};
      return ~{u, bb, d, l, r, c};
    end
    if (ph == 3) return {1'b0, ~a, 3'b000, ~st};
    if (ph == 4) return {1'b1, ~a, 3'b111, ~st};
    return {~u, ~a, ~d, 2'b00, ~st};
  endfunction

  int          m_count;
  logic [11:0] m_snap;
  int          m_frames;
  int          gap;
  logic [11:0] eff;

  initial begin
    // Frame 1: A+START+Z+MODE
    tbl.push_back('{1'b1, 30, 12'h087, 0, 6'h3F, 6'h3F});
    tbl.push_back('{1'b0, 20, 12'h087, 1, 6'h28, 6'h28});
    tbl.push_back('{1'b1, 20, 12'h087, 1, 6'h3F, 6'h3F});
    tbl.push_back('{1'b0, 20, 12'h087, 2, 6'h28, 6'h28});
    tbl.push_back('{1'b1, 20, 12'h087, 2, 6'h3F, 6'h3F});
    tbl.push_back('{1'b0, 20, 12'h087, 3, 6'h00, 6'h28});
    tbl.push_back('{1'b1, 20, 12'h087, 3, 6'h1D, 6'h3F});
    tbl.push_back('{1'b0, 20, 12'h087, 4, 6'h2E, 6'h28});
    tbl.push_back('{1'b1, 20, 12'h087, 4, 6'h3F, 6'h3F});
    tbl.push_back('{1'b1, 60, 12'h087, 0, 6'h3F, 6'h3F});
    // Frame 2: UP+C
    tbl.push_back('{1'b1, 10, 12'h820, 0, 6'h1E, 6'h1E});
    tbl.push_back('{1'b0, 20, 12'h820, 1, 6'h19, 6'h19});
    tbl.push_back('{1'b1, 20, 12'h820, 1, 6'h1E, 6'h1E});
    tbl.push_back('{1'b0, 20, 12'h820, 2, 6'h19, 6'h19});
    tbl.push_back('{1'b1, 20, 12'h820, 2, 6'h1E, 6'h1E});
    tbl.push_back('{1'b0, 20, 12'h820, 3, 6'h11, 6'h19});
    tbl.push_back('{1'b1, 20, 12'h820, 3, 6'h3E, 6'h1E});
    tbl.push_back('{1'b0, 20, 12'h820, 4, 6'h3F, 6'h19});
    tbl.push_back('{1'b1, 20, 12'h820, 4, 6'h1E, 6'h1E});
    tbl.push_back('{1'b1, 60, 12'h820, 0, 6'h1E, 6'h1E});
    // Frame 3: B pressed at low #1, switched to X mid-frame
    tbl.push_back('{1'b1, 10, 12'h040, 0, 6'h2F, 6'h2F});
    tbl.push_back('{1'b0, 20, 12'h040, 1, 6'h39, 6'h39});
    tbl.push_back('{1'b1, 20, 12'h010, 1, 6'h2F, 6'h2F});
    tbl.push_back('{1'b0, 20, 12'h010, 2, 6'h39, 6'h39});
    tbl.push_back('{1'b1, 20, 12'h010, 2, 6'h2F, 6'h2F});
    tbl.push_back('{1'b0, 20, 12'h010, 3, 6'h11, 6'h39});
    tbl.push_back('{1'b1, 20, 12'h010, 3, 6'h2F, 6'h2F});
    tbl.push_back('{1'b0, 20, 12'h010, 4, 6'h3F, 6'h39});
    tbl.push_back('{1'b1, 20, 12'h010, 4, 6'h2F, 6'h2F});
    tbl.push_back('{1'b1, 60, 12'h010, 0, 6'h3F, 6'h3F});
    // Frame 4: X now in the snapshot
    tbl.push_back('{1'b0, 20, 12'h010, 1, 6'h39, 6'h39});
    tbl.push_back('{1'b1, 20, 12'h010, 1, 6'h3F, 6'h3F});
    tbl.push_back('{1'b0, 20, 12'h010, 2, 6'h39, 6'h39});
    tbl.push_back('{1'b1, 20, 12'h010, 2, 6'h3F, 6'h3F});
    tbl.push_back('{1'b0, 20, 12'h010, 3, 6'h11, 6'h39});
    tbl.push_back('{1'b1, 20, 12'h010, 3, 6'h3B, 6'h3F});

    reset = 1'b1;
    sel   = 1'b1;
    btns  = '0;
    wait_cycles(3);
    check("reset_pins6", if6.controller_pins, 6'h3F);
    check("reset_pins3", if3.controller_pins, 6'h3F);
    check("reset_cnt6", if6.pulse_count, 3'd0);
    check("reset_fs6", if6.frame_start, 1'b0);
    reset = 1'b0;
    wait_cycles(5);
    check("idle_pins6", if6.controller_pins, 6'h3F);
    check("idle_cnt6", if6.pulse_count, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      sel  = tbl[i].s;
      btns = tbl[i].b;
      wait_cycles(tbl[i].wait_n);
      check($sformatf("tbl%0d_pins6", i), if6.controller_pins, tbl[i].p6);
      check($sformatf("tbl%0d_pins3", i), if3.controller_pins, tbl[i].p3);
      check($sformatf("tbl%0d_cnt6", i), if6.pulse_count, tbl[i].cnt);
      check($sformatf("tbl%0d_cnt3", i), if3.pulse_count, tbl[i].cnt);
    end
    check("tbl_frames6", fr6, 4);
    check("tbl_frames3", fr3, 4);

    // Reset asserted mid-frame with select low at count 3
    wait_cycles(60);
    sel = 1'b0; wait_cycles(10);
    sel = 1'b1; wait_cycles(10);
    sel = 1'b0; wait_cycles(10);
    sel = 1'b1; wait_cycles(10);
    sel = 1'b0; wait_cycles(10);
    check("pre_rst_cnt6", if6.pulse_count, 3'd3);
    check("pre_rst_pins6", if6.controller_pins, 6'h11);
    reset = 1'b1;
    #1;
    check("rst_pins6", if6.controller_pins, 6'h3F);
    check("rst_pins3", if3.controller_pins, 6'h3F);
    check("rst_cnt6", if6.pulse_count, 3'd0);
    check("rst_fs6", if6.frame_start, 1'b0);
    sel = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(10);
    sel = 1'b0;
    wait_cycles(10);
    check("post_rst_cnt6", if6.pulse_count, 3'd1);
    check("post_rst_cnt3", if3.pulse_count, 3'd1);
    check("post_rst_frames6", fr6, 6);
    check("post_rst_frames3", fr3, 6);

    // Random traffic against the phase model
    sel = 1'b1;
    wait_cycles(60);
    m_count  = 0;
    m_snap   = '0;
    m_frames = 6;
    for (int step = 0; step < 150; step++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 80))
                                        : int'($urandom_range(5, 35));
      if ($urandom_range(0, 1) == 1) btns = 12'($urandom);
      sel = ~sel;
      if (!sel) begin
        if (m_count == 0 || m_count == 4) begin
          m_count = 1;
          m_snap  = btns;
          m_frames++;
        end else begin
          m_count++;
        end
      end
      wait_cycles(gap);
      if (gap > int'(TO) + 5) m_count = 0;
      eff = (m_count == 0) ? btns : m_snap;
      check($sformatf("rnd%0d_pins6", step), if6.controller_pins, model_pins(1'b1, m_count, sel, eff));
      check($sformatf("rnd%0d_pins3", step), if3.controller_pins, model_pins(1'b0, m_count, sel, eff));
      check($sformatf("rnd%0d_cnt6", step), if6.pulse_count, m_count);
      check($sformatf("rnd%0d_cnt3", step), if3.pulse_count, m_count);
      check($sformatf("rnd%0d_frames6", step), fr6, m_frames);
      check($sformatf("rnd%0d_frames3", step), fr3, m_frames);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
